// File: rtl/ro_freq_meter.sv
// Gated ring-oscillator edge counter: counts synchronized rising edges of ro_in
// over a programmable window of clk cycles and holds the saturating result.
module ro_freq_meter #(
   parameter int CNT_W  = 16,
   parameter int GATE_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ro_in,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_sync;
   logic              w_rise;
   logic [GATE_W-1:0] r_gate_cnt;
   logic [GATE_W-1:0] w_gate_cnt_next;
   logic [CNT_W-1:0]  r_edge_cnt;
   logic [CNT_W-1:0]  w_edge_cnt_next;
   logic              r_sat;
   logic              w_sat_next;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_next;
   logic              r_overflow;
   logic              w_overflow_next;

   // Two flops resolve metastability; the third gives the previous level for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= 3'b000;
      end else begin
         r_sync <= {r_sync[1:0], ro_in};
      end
   end

   assign w_rise = r_sync[1] & ~r_sync[2];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_gate_cnt_next = r_gate_cnt;
      w_edge_cnt_next = r_edge_cnt;
      w_sat_next      = r_sat;
      w_count_next    = r_count;
      w_overflow_next = r_overflow;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_edge_cnt_next = '0;
               w_sat_next      = 1'b0;
               if (gate_len != '0) begin
                  w_gate_cnt_next = gate_len;
                  w_state_next    = S_ARM;
               end else begin
                  w_count_next    = '0;
                  w_overflow_next = 1'b0;
                  w_state_next    = S_DONE;
               end
            end
         end
         S_ARM: begin
            w_state_next = S_COUNT;
         end
         S_COUNT: begin
            if (w_rise) begin
               if (&r_edge_cnt) begin
                  w_sat_next = 1'b1;
               end else begin
                  w_edge_cnt_next = r_edge_cnt + CNT_ONE;
               end
            end
            w_gate_cnt_next = r_gate_cnt - GATE_ONE;
            // The final window cycle's edge is folded into the published result.
            if (r_gate_cnt == GATE_ONE) begin
               w_count_next    = w_edge_cnt_next;
               w_overflow_next = w_sat_next;
               w_state_next    = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_sat      <= 1'b0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_gate_cnt <= w_gate_cnt_next;
         r_edge_cnt <= w_edge_cnt_next;
         r_sat      <= w_sat_next;
         r_count    <= w_count_next;
         r_overflow <= w_overflow_next;
      end
   end

   assign busy     = (r_state == S_ARM) || (r_state == S_COUNT);
   assign done     = (r_state == S_DONE);
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule
